// File: rtl/cpu_pkg.sv
// Shared definitions for the RV32IM front end.
//   INSTR_W       : instruction / PC width
//   RESET_PC      : PC loaded while rst_n is low
//   fetch_entry_t : one prefetch queue entry, {instr, pc}
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] RESET_PC = 32'hBFC0_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [INSTR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry circular buffer between the fetch PC and decode.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : empty the queue and rewind both pointers (beats push/pop)
//   push       : write wr_data at the tail this cycle
//   pop        : retire the head entry this cycle
//   wr_data    : entry to write
//   head       : current head entry, all zeros while empty
//   count      : number of valid entries, 0..DEPTH
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  entry_t           wr_data,
  output entry_t           head,
  output logic [CNT_W-1:0] count
);

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;

  // NOTE: storage is reset here so head never exposes X after reset; for a
  // larger queue this would be dropped and the empty mask below relied on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !flush) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap by plain overflow.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // A popped slot keeps its old contents, so mask the head while empty.
  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, addresses the combinational instruction ROM and
// queues {instr, pc} pairs for decode.
//   clk, rst_n        : clock, asynchronous active-low reset
//   imem_addr         : ROM byte address, pc truncated to ROM_WIDTH bits
//   imem_rd           : ROM word for imem_addr, same cycle
//   redirect_valid/pc : branch/jump target; flushes the queue, reloads PC
//   out_valid/ready   : decode handshake on the queue head
//   out_instr         : head instruction word
//   out_pc            : PC of the head instruction
//   out_pc_plus4      : out_pc + 4 (0 while the queue is empty)
module instr_fetch_unit #(
  parameter int                     ROM_WIDTH  = 12,
  parameter int                     DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]  RESET_PC   = cpu_pkg::RESET_PC,
  parameter int                     DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ROM_WIDTH-1:0]  imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rd,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_pc_plus4
);

  import cpu_pkg::*;

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] pc;
  logic [CNT_W-1:0]      q_count;
  logic                  push;
  logic                  pop;
  fetch_entry_t          wr_entry;
  fetch_entry_t          head;
  logic                  unused_rpc_bits;

  // A pop frees its slot in the same cycle, so a full queue that is being
  // drained still accepts the next fetch. Redirect suppresses the fetch.
  assign pop  = out_valid && out_ready;
  assign push = !redirect_valid && ((q_count < CNT_W'(DEPTH)) || pop);

  // Targets are word aligned; the low two bits are dropped, not trapped.
  assign unused_rpc_bits = ^redirect_pc[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= {redirect_pc[DATA_WIDTH-1:2], 2'b00};
    end else if (push) begin
      pc <= pc + DATA_WIDTH'(4);
    end
  end

  assign imem_addr = pc[ROM_WIDTH-1:0];
  assign wr_entry  = '{instr: imem_rd, pc: pc};

  fetch_queue #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (redirect_valid),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .head    (head),
    .count   (q_count)
  );

  assign out_valid    = (q_count != '0);
  assign out_instr    = head.instr;
  assign out_pc       = head.pc;
  assign out_pc_plus4 = out_valid ? head.pc + DATA_WIDTH'(4) : '0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a table of per-cycle vectors,
// hand-written corner-case sequences and a randomized run against a
// queue-based reference model.
module tb_instr_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RST_PC   = 32'hBFC0_0000;
  localparam logic [31:0] ROM_BASE = 32'h00A0_0093;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] imem_addr;
  logic [31:0] imem_rd;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_rd        (imem_rd),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4)
  );

  // Combinational ROM: word at byte address a is ROM_BASE + a.
  assign imem_rd = ROM_BASE + {20'h0, imem_addr};

  function automatic logic [31:0] rom_word(input logic [31:0] pc);
    return ROM_BASE + {20'h0, pc[11:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input bit exp_valid,
                               input logic [31:0] exp_pc, input logic [11:0] exp_addr,
                               input int exp_cnt);
    check({tag, " valid"}, {31'h0, out_valid}, {31'h0, exp_valid});
    check({tag, " addr"},  {20'h0, imem_addr}, {20'h0, exp_addr});
    check({tag, " count"}, 32'(dut.q_count), 32'(exp_cnt));
    check({tag, " pc"},    out_pc,       exp_valid ? exp_pc : 32'h0);
    check({tag, " instr"}, out_instr,    exp_valid ? rom_word(exp_pc) : 32'h0);
    check({tag, " pc+4"},  out_pc_plus4, exp_valid ? exp_pc + 32'd4 : 32'h0);
  endtask

  // Reset is released just after a rising edge (synchronous deassertion);
  // that edge is the first edge of the release, the next one fetches.
  task automatic do_reset();
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    rst_n          = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Drive inputs for one cycle at the falling edge, then let outputs settle.
  task automatic cycle_drive(input bit ready, input bit redir, input logic [31:0] rpc);
    @(negedge clk);
    out_ready      = ready;
    redirect_valid = redir;
    redirect_pc    = rpc;
    #1;
  endtask

  typedef struct {
    bit          rst;
    bit          ready;
    bit          redir;
    logic [31:0] rpc;
    bit          exp_valid;
    logic [31:0] exp_pc;
    logic [11:0] exp_addr;
    int          exp_cnt;
  } vec_t;

  vec_t vecs[$];

  // Reference model: a queue of fetched PCs plus the fetch PC.
  logic [31:0] mq[$];
  logic [31:0] mpc;

  task automatic model_step(input bit ready, input bit redir, input logic [31:0] rpc);
    bit popping;
    bit room;
    if (redir) begin
      mq.delete();
      mpc = {rpc[31:2], 2'b00};
    end else begin
      popping = (mq.size() > 0) && ready;
      room    = (mq.size() < DEPTH) || popping;
      if (popping) void'(mq.pop_front());
      if (room) begin
        mq.push_back(mpc);
        mpc = mpc + 32'd4;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    // ---- Table: streaming from reset, then backpressure and redirect ----
    // Streaming with ready=1: out_valid rises on the 2nd edge of the release.
    vecs.push_back('{1, 1, 0, 32'h0, 0, 32'h0,        12'h000, 0});
    vecs.push_back('{0, 1, 0, 32'h0, 1, 32'hBFC00000, 12'h004, 1});
    vecs.push_back('{0, 1, 0, 32'h0, 1, 32'hBFC00004, 12'h008, 1});
    vecs.push_back('{0, 1, 0, 32'h0, 1, 32'hBFC00008, 12'h00C, 1});
    // Backpressure: ready=0 for 5 cycles, queue saturates, PC holds at 008.
    vecs.push_back('{1, 0, 0, 32'h0, 0, 32'h0,        12'h000, 0});
    vecs.push_back('{0, 0, 0, 32'h0, 1, 32'hBFC00000, 12'h004, 1});
    vecs.push_back('{0, 0, 0, 32'h0, 1, 32'hBFC00000, 12'h008, 2});
    vecs.push_back('{0, 0, 0, 32'h0, 1, 32'hBFC00000, 12'h008, 2});
    vecs.push_back('{0, 0, 0, 32'h0, 1, 32'hBFC00000, 12'h008, 2});
    // Release: no gap, no duplication.
    vecs.push_back('{0, 1, 0, 32'h0, 1, 32'hBFC00000, 12'h008, 2});
    vecs.push_back('{0, 1, 0, 32'h0, 1, 32'hBFC00004, 12'h00C, 2});
    vecs.push_back('{0, 1, 0, 32'h0, 1, 32'hBFC00008, 12'h010, 2});
    // Redirect while full and popping, unaligned target.
    vecs.push_back('{0, 1, 1, 32'hBFC00103, 1, 32'hBFC0000C, 12'h014, 2});
    vecs.push_back('{0, 1, 0, 32'h0, 0, 32'h0,        12'h100, 0});
    vecs.push_back('{0, 1, 0, 32'h0, 1, 32'hBFC00100, 12'h104, 1});

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      cycle_drive(vecs[i].ready, vecs[i].redir, vecs[i].rpc);
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_pc,
                    vecs[i].exp_addr, vecs[i].exp_cnt);
    end

    // ---- Full queue with simultaneous push/pop for 10 cycles ----
    do_reset();
    cycle_drive(0, 0, 32'h0);
    cycle_drive(0, 0, 32'h0);
    for (int k = 0; k < 10; k++) begin
      cycle_drive(1, 0, 32'h0);
      check($sformatf("steady%0d count", k), 32'(dut.q_count), 32'd2);
      check($sformatf("steady%0d pc", k), out_pc, RST_PC + 32'(4 * k));
    end

    // ---- PC wrap through 2^32 ----
    cycle_drive(1, 1, 32'hFFFFFFFC);
    cycle_drive(0, 0, 32'h0);
    check_outputs("wrap0", 0, 32'h0, 12'hFFC, 0);
    cycle_drive(0, 0, 32'h0);
    check_outputs("wrap1", 1, 32'hFFFFFFFC, 12'h000, 1);
    cycle_drive(1, 0, 32'h0);
    check_outputs("wrap2", 1, 32'hFFFFFFFC, 12'h004, 2);
    cycle_drive(1, 0, 32'h0);
    check_outputs("wrap3", 1, 32'h00000000, 12'h008, 2);

    // ---- Asynchronous reset mid-stream ----
    repeat (3) cycle_drive(1, 0, 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_outputs("async_rst", 0, 32'h0, 12'h000, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle_drive(1, 0, 32'h0);
    check_outputs("restart0", 0, 32'h0, 12'h000, 0);
    cycle_drive(1, 0, 32'h0);
    check_outputs("restart1", 1, RST_PC, 12'h004, 1);
    cycle_drive(1, 0, 32'h0);
    check_outputs("restart2", 1, RST_PC + 32'd4, 12'h008, 1);

    // ---- Randomized run against the reference model ----
    do_reset();
    mq.delete();
    mpc = RST_PC;
    for (int n = 0; n < 400; n++) begin
      bit          ready;
      bit          redir;
      logic [31:0] rpc;
      ready = ($urandom_range(0, 99) < 70);
      redir = ($urandom_range(0, 15) == 0);
      rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15)))
                                          : 32'($urandom);
      cycle_drive(ready, redir, rpc);
      check_outputs($sformatf("rand%0d", n), mq.size() > 0,
                    (mq.size() > 0) ? mq[0] : 32'h0, mpc[11:0], mq.size());
      model_step(ready, redir, rpc);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Front end of the RV32IM pipeline. It owns the program counter and drives the byte address into the combinational instruction ROM. It captures each returned 32-bit word, tagged with its PC, into a small prefetch queue. The queue feeds decode over a valid/ready handshake. Redirects from branch/jump resolution flush the queue and reload the PC.

Parameters:
ROM_WIDTH, 12, ROM byte-address width driven on imem_addr
DATA_WIDTH, 32, instruction/PC width
RESET_PC, 32'hBFC00000, PC value loaded on reset
DEPTH, 2, prefetch queue entries (power of two, >=2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_addr  out  ROM_WIDTH  byte address to ROM = pc[ROM_WIDTH-1:0]
imem_rd  in  DATA_WIDTH  ROM word for imem_addr, valid same cycle (combinational ROM)
redirect_valid  in  1  load new PC and flush queue
redirect_pc  in  DATA_WIDTH  target PC
out_valid  out  1  queue head holds an instruction
out_ready  in  1  decode accepts head this cycle
out_instr  out  DATA_WIDTH  head instruction word, passed through unmodified
out_pc  out  DATA_WIDTH  PC of head instruction
out_pc_plus4  out  DATA_WIDTH  out_pc + 4, mod 2^32

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous, active-low, and deasserts synchronously externally.
- Reset values: pc=RESET_PC, count=0, rd/wr pointers=0, out_valid=0. out_instr, out_pc and out_pc_plus4 read 0 when count=0 (storage is cleared at reset and never read while empty).
- pop = out_valid && out_ready.
- push = !redirect_valid && (count<DEPTH || pop). A pop frees a slot in the same cycle, so a full queue with pop still pushes.
- On push at the clock edge:
  - Entry {imem_rd, pc} is written at wr_ptr.
  - pc <= pc+4, wrapping mod 2^32.
  - wr_ptr advances, modulo DEPTH.
- On pop: rd_ptr advances.
- count update: count <= count + push - pop.
- redirect_valid=1 (highest priority, overrides push and pop):
  - pc <= {redirect_pc[31:2], 2'b00}; the low two bits are silently cleared.
  - count <= 0 and both pointers are reset.
  - out_valid is 0 in the following cycle.
  - Any handshake completing in the redirect cycle is still counted as accepted by decode. The fetch unit does not re-present that instruction.
- Latency:
  - The PC presented in cycle N appears at the head at cycle N+1 if the queue was empty.
  - First instruction after reset release: out_valid=1 on the 2nd rising edge after rst_n rises, with out_pc=RESET_PC.
- Throughput: one instruction per cycle while out_ready=1.
- Backpressure: with out_ready=0, the queue fills to DEPTH after DEPTH cycles. After that, pc holds and imem_addr is stable.
- out_* are driven combinationally from the head entry. They must hold stable while out_valid && !out_ready.
- imem_addr simply truncates pc. Wrap at ROM size is the ROM's concern, not flagged.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Queued entries are discarded.

Decomposition:
- Shared package cpu_pkg holds:
  - RESET_PC constant
  - typedef fetch_entry_t {instr, pc} of DATA_WIDTH fields
  - INSTR_W=32
- One sub-module, fetch_queue: a DEPTH-entry circular buffer with push/pop/flush, count and head output. Parameterised by DEPTH and entry type.
- The PC register, next-PC mux and handshake logic stay in instr_fetch_unit.

Test Plan:
- Reset then out_ready=1, ROM word at address a = 32'h00A00093 + a → out_pc sequence BFC00000, BFC00004, BFC00008 on consecutive cycles, with the matching instr on each. out_valid first rises 2 edges after reset release.
- Backpressure: out_ready=0 for 5 cycles from reset:
  - count saturates at 2.
  - imem_addr holds at 12'h008.
  - out_pc stays BFC00000.
  - Then ready=1 → BFC00000, 004, 008 delivered with no gap and no duplication.
- Redirect while queue is full and pop is active, redirect_pc=BFC00103:
  - Next cycle: out_valid=0, imem_addr=12'h100.
  - Following cycle: out_pc=BFC00100 and out_pc_plus4=BFC00104.
- Full queue with simultaneous pop and push for 10 cycles, ready=1 → count stays 2 and PCs are strictly consecutive.
- PC wrap: redirect to FFFFFFFC → entries at FFFFFFFC then 00000000; out_pc_plus4 of the first is 00000000.
- Assert rst_n=0 mid-stream for 1 cycle → out_valid drops immediately (asynchronous). After release, the stream restarts at BFC00000.
